bsg_rocc_mem_req_tracker: RTL and testbench
===========================================

// Module: bsg_rocc_mem_req_tracker
// PURPOSE
//  Downstream of the manycore->RoCC link converter, on the Rocket memory port.
//  Buffers rocc_mem_req_s requests and issues each one with a unique tag.
//  Tracks outstanding tags, retires them on tag-matched responses, and reports busy/error status.
//  This allows more than one pending Rocket memory request without losing response ownership.
// PARAMETERS
//  fifo_els_p        4    depth of input request FIFO (>=2)
//  max_outstanding_p 4    max in-flight tags; must be <= 2**rocc_mem_tag_width_gp
//  timeout_cycles_p  1024 per-tag response deadline (only with BSG_ROCC_MEM_TRACKER_TIMEOUT_EN)
// PORTS
//  clk_i             in   1    Rocket clock; only clock
//  reset_i           in   1    asynchronous, active-high reset
//  req_v_i           in   1    upstream request valid
//  req_s_i           in   rocc_mem_req_s  upstream request; req_tag field ignored
//  req_ready_o       out  1    FIFO not full (valid/ready)
//  mem_req_valid_o   out  1    request to Rocket memory
//  mem_req_s_o       out  rocc_mem_req_s  request with tracker-assigned req_tag
//  mem_req_ready_i   in   1    Rocket memory accepts request
//  mem_resp_valid_i  in   1    Rocket response valid (no backpressure)
//  mem_resp_s_i      in   rocc_mem_resp_s  response; resp_tag selects retired entry
//  outstanding_o     out  $clog2(max_outstanding_p+1)  in-flight tag count
//  busy_o            out  1    FIFO non-empty OR any tag outstanding
//  error_o           out  1    sticky: response arrived for a tag that is not outstanding
//  timeout_o         out  1    sticky: outstanding tag exceeded deadline
// BEHAVIOUR
//  - Reset (async assert, sync deassert use): FIFO emptied, outstanding vector=0, error_o=0, timeout_o=0.
//    After reset: req_ready_o=1, mem_req_valid_o=0, outstanding_o=0, busy_o=0.
//    Reset mid-operation drops queued requests and all tag state. Late responses after reset set error_o.
//  - Enqueue: on req_v_i & req_ready_o, captured into the registered FIFO.
//    Earliest mem_req_valid_o is the next cycle (1-cycle latency).
//  - Issue: mem_req_valid_o = FIFO non-empty & free tag exists.
//    Tag = lowest free index. mem_req_s_o = FIFO head with req_tag replaced by that tag; other fields pass through unmodified.
//    On valid & mem_req_ready_i: the head is dequeued and the tag bit is set.
//    mem_req_valid_o does not depend combinationally on mem_req_ready_i.
//  - Full: outstanding_o==max_outstanding_p -> mem_req_valid_o=0 and the FIFO holds.
//    FIFO full -> req_ready_o=0.
//  - Retire: on mem_resp_valid_i with resp_tag < max_outstanding_p and its bit set, the bit is cleared the same edge.
//    Otherwise error_o is set. The response is consumed with no state change, and error_o stays set until reset.
//  - Simultaneous issue + retire in one cycle: both apply; outstanding_o is unchanged.
//    A tag cleared this cycle is allocatable the next cycle, not the same cycle.
//  - Enqueue into an empty FIFO does not bypass to mem_req_s_o.
//  - outstanding_o = popcount of the outstanding vector, registered alongside it.
// CONFIGURATION
//  `BSG_ROCC_MEM_TRACKER_TIMEOUT_EN defined:
//    - One counter per tag, each $clog2(timeout_cycles_p+1) bits.
//    - A counter clears on issue and increments while its tag is outstanding, saturating at timeout_cycles_p.
//    - Reaching timeout_cycles_p sets timeout_o (sticky). The tag stays outstanding.
//  Not defined: no counters are built, timeout_o is tied to 0, and timeout_cycles_p is unused.
// STRUCTURE
//  - The shared bsg_rocc header/package owns rocc_mem_req_s, rocc_mem_resp_s, rocc_mem_tag_width_gp and rocc_data_width_gp.
//    These are reused, not redeclared. This module adds no new shared types.
//  - Sub-module bsg_rocc_mem_tag_alloc holds:
//    - the outstanding bit vector
//    - a lowest-free priority encoder (free_v_o, free_tag_o)
//    - set/clear ports and the popcount
//  - The top level holds the FIFO, issue logic, error/timeout flags and optional timeout counters.
// TESTING
//  1. Reset, then 3 back-to-back stores, with mem_req_ready_i=1 and responses returned 5 cycles later in order
//     -> tags 0,1,2 issued; outstanding_o peaks at 3 and returns to 0; busy_o falls.
//  2. mem_req_ready_i=0 with 6 pushes and fifo_els_p=4
//     -> req_ready_o=0 after 4 pushes; mem_req_valid_o held at 1 with stable payload and tag 0.
//  3. 4 issued, no responses
//     -> mem_req_valid_o=0 with FIFO non-empty. A response with tag 2 lets the next request issue next cycle with tag 2.
//  4. Response for tag 1 arriving in the same cycle as tag 3 is issued
//     -> outstanding_o unchanged; tag 1 is reused on the following issue.
//  5. Response with a never-issued tag 3
//     -> error_o=1 and stays 1; outstanding_o unchanged. reset_i clears error_o.
//  6. With macro defined and timeout_cycles_p=16: issue 1, withhold its response
//     -> timeout_o=1 exactly 16 cycles after issue. Without the macro, timeout_o stays 0.

Source files
------------

// File: rtl/bsg_rocc_pkg.sv
// Shared bsg_rocc definitions: RoCC memory request/response bundles
// and the tag/data widths used across the manycore<->RoCC path.
package bsg_rocc_pkg;

    localparam int rocc_mem_tag_width_gp = 5;
    localparam int rocc_data_width_gp    = 64;
    localparam int rocc_addr_width_gp    = 40;

    typedef struct packed {
        logic [rocc_addr_width_gp-1:0]    req_addr;
        logic [rocc_mem_tag_width_gp-1:0] req_tag;
        logic [4:0]                       req_cmd;
        logic [2:0]                       req_typ;
        logic                             req_phys;
        logic [rocc_data_width_gp-1:0]    req_data;
    } rocc_mem_req_s;

    typedef struct packed {
        logic [rocc_addr_width_gp-1:0]    resp_addr;
        logic [rocc_mem_tag_width_gp-1:0] resp_tag;
        logic [4:0]                       resp_cmd;
        logic [2:0]                       resp_typ;
        logic [rocc_data_width_gp-1:0]    resp_data;
        logic                             resp_has_data;
    } rocc_mem_resp_s;

endpackage

// File: rtl/bsg_rocc_mem_tag_alloc.sv
// Outstanding-tag vector with lowest-free allocation and a registered
// popcount kept in step with the vector.
module bsg_rocc_mem_tag_alloc #(
    parameter int els_p = 4,
    localparam int idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cnt_w_lp = $clog2(els_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                set_v_i,
    input  logic [idx_w_lp-1:0] set_idx_i,
    input  logic                clr_v_i,
    input  logic [idx_w_lp-1:0] clr_idx_i,
    output logic [els_p-1:0]    vec_o,
    output logic                free_v_o,
    output logic [idx_w_lp-1:0] free_tag_o,
    output logic [cnt_w_lp-1:0] count_o
);

    logic [els_p-1:0]    vec_r;
    logic [els_p-1:0]    vec_next;
    logic [cnt_w_lp-1:0] count_r;

    function automatic logic [cnt_w_lp-1:0] popcount(input logic [els_p-1:0] v);
        logic [cnt_w_lp-1:0] c;
        c = '0;
        for (int i = 0; i < els_p; i++) begin
            c = c + cnt_w_lp'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        vec_next = vec_r;
        if (set_v_i) vec_next[set_idx_i] = 1'b1;
        if (clr_v_i) vec_next[clr_idx_i] = 1'b0;
    end

    // Scan from the top so the lowest free index wins.
    always_comb begin
        free_v_o   = 1'b0;
        free_tag_o = '0;
        for (int i = els_p - 1; i >= 0; i--) begin
            if (!vec_r[i]) begin
                free_v_o   = 1'b1;
                free_tag_o = idx_w_lp'(i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vec_r   <= '0;
            count_r <= '0;
        end else begin
            vec_r   <= vec_next;
            count_r <= popcount(vec_next);
        end
    end

    assign vec_o   = vec_r;
    assign count_o = count_r;

endmodule

// File: rtl/bsg_rocc_mem_req_tracker.sv
// Buffers RoCC memory requests, tags them, and retires tags on responses.
// Optional per-tag deadline: BSG_ROCC_MEM_TRACKER_TIMEOUT_EN.
module bsg_rocc_mem_req_tracker
    import bsg_rocc_pkg::*;
#(
    parameter int fifo_els_p        = 4,
    parameter int max_outstanding_p = 4,
    parameter int timeout_cycles_p  = 1024,
    localparam int cnt_w_lp = $clog2(max_outstanding_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                req_v_i,
    input  rocc_mem_req_s       req_s_i,
    output logic                req_ready_o,
    output logic                mem_req_valid_o,
    output rocc_mem_req_s       mem_req_s_o,
    input  logic                mem_req_ready_i,
    input  logic                mem_resp_valid_i,
    input  rocc_mem_resp_s      mem_resp_s_i,
    output logic [cnt_w_lp-1:0] outstanding_o,
    output logic                busy_o,
    output logic                error_o,
    output logic                timeout_o
);

    localparam int tw_lp    = rocc_mem_tag_width_gp;
    localparam int iw_lp    = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int fcw_lp   = $clog2(fifo_els_p + 1);

    rocc_mem_req_s       fifo_mem [fifo_els_p];
    logic [ptr_w_lp-1:0] wr_ptr, rd_ptr;
    logic [fcw_lp-1:0]   fifo_cnt;
    logic                fifo_v, enq, deq;

    logic [max_outstanding_p-1:0] vec;
    logic                         free_v;
    logic [iw_lp-1:0]             free_tag;
    logic                         resp_hit, clr_v;
    logic [iw_lp-1:0]             resp_idx;
    logic                         error_r;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_v          = (fifo_cnt != '0);
    assign req_ready_o     = (fifo_cnt != fcw_lp'(fifo_els_p));
    assign enq             = req_v_i & req_ready_o;
    assign mem_req_valid_o = fifo_v & free_v;
    assign deq             = mem_req_valid_o & mem_req_ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (enq) wr_ptr <= ptr_inc(wr_ptr);
            if (deq) rd_ptr <= ptr_inc(rd_ptr);
            unique case ({enq, deq})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) fifo_mem[wr_ptr] <= req_s_i;
    end

    always_comb begin
        mem_req_s_o         = fifo_mem[rd_ptr];
        mem_req_s_o.req_tag = tw_lp'(free_tag);
    end

    // Tags at or above max_outstanding_p can never be live, so they miss.
    assign resp_idx = mem_resp_s_i.resp_tag[iw_lp-1:0];
    assign resp_hit = ({1'b0, mem_resp_s_i.resp_tag} < (tw_lp + 1)'(max_outstanding_p))
                    && vec[resp_idx];
    assign clr_v    = mem_resp_valid_i & resp_hit;

    bsg_rocc_mem_tag_alloc #(
        .els_p(max_outstanding_p)
    ) tag_alloc (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .set_v_i    (deq),
        .set_idx_i  (free_tag),
        .clr_v_i    (clr_v),
        .clr_idx_i  (resp_idx),
        .vec_o      (vec),
        .free_v_o   (free_v),
        .free_tag_o (free_tag),
        .count_o    (outstanding_o)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            error_r <= 1'b0;
        end else if (mem_resp_valid_i && !resp_hit) begin
            error_r <= 1'b1;
        end
    end

    assign error_o = error_r;
    assign busy_o  = fifo_v | (outstanding_o != '0);

`ifdef BSG_ROCC_MEM_TRACKER_TIMEOUT_EN
    localparam int tcw_lp = $clog2(timeout_cycles_p + 1);

    logic [tcw_lp-1:0] tcnt_r [max_outstanding_p];
    logic              timeout_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < max_outstanding_p; i++) tcnt_r[i] <= '0;
            timeout_r <= 1'b0;
        end else begin
            for (int i = 0; i < max_outstanding_p; i++) begin
                if (deq && free_tag == iw_lp'(i)) begin
                    tcnt_r[i] <= '0;
                end else if (vec[i] && tcnt_r[i] != tcw_lp'(timeout_cycles_p)) begin
                    tcnt_r[i] <= tcnt_r[i] + 1'b1;
                    if (tcnt_r[i] == tcw_lp'(timeout_cycles_p - 1)) timeout_r <= 1'b1;
                end
            end
        end
    end

    assign timeout_o = timeout_r;
`else
    assign timeout_o = 1'b0;
`endif

    logic unused_resp;
    assign unused_resp = ^{mem_resp_s_i.resp_addr, mem_resp_s_i.resp_cmd,
                           mem_resp_s_i.resp_typ, mem_resp_s_i.resp_data,
                           mem_resp_s_i.resp_has_data};

endmodule

// File: tb/tb_bsg_rocc_mem_req_tracker.sv
// Scenario bench for bsg_rocc_mem_req_tracker with a scoreboarded
// request path and a reference tag model.
module tb_bsg_rocc_mem_req_tracker;
    import bsg_rocc_pkg::*;

    localparam int FIFO = 4;
    localparam int MAXO = 4;
    localparam int TO   = 16;
    localparam int CW   = $clog2(MAXO + 1);

    logic           clk = 1'b0;
    logic           reset_i;
    logic           req_v_i;
    rocc_mem_req_s  req_s_i;
    logic           req_ready_o;
    logic           mem_req_valid_o;
    rocc_mem_req_s  mem_req_s_o;
    logic           mem_req_ready_i;
    logic           mem_resp_valid_i;
    rocc_mem_resp_s mem_resp_s_i;
    logic [CW-1:0]  outstanding_o;
    logic           busy_o;
    logic           error_o;
    logic           timeout_o;

    int checks   = 0;
    int failures = 0;

    rocc_mem_req_s   exp_q[$];
    logic [MAXO-1:0] m_vec;
    logic            m_err;

    always #5 clk = ~clk;

    bsg_rocc_mem_req_tracker #(
        .fifo_els_p       (FIFO),
        .max_outstanding_p(MAXO),
        .timeout_cycles_p (TO)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .req_v_i         (req_v_i),
        .req_s_i         (req_s_i),
        .req_ready_o     (req_ready_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_s_o     (mem_req_s_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_s_i    (mem_resp_s_i),
        .outstanding_o   (outstanding_o),
        .busy_o          (busy_o),
        .error_o         (error_o),
        .timeout_o       (timeout_o)
    );

    function automatic rocc_mem_req_s mk(input int i);
        rocc_mem_req_s r;
        r.req_addr = 40'h10_0000_1000 + 40'(i * 8);
        r.req_tag  = 5'h1f ^ 5'(i);
        r.req_cmd  = (i % 2 == 1) ? 5'd1 : 5'd0;
        r.req_typ  = 3'(i);
        r.req_phys = i[0];
        r.req_data = {32'(i), 32'hdead_0000 | 32'(i)};
        return r;
    endfunction

    function automatic int lowest_free(input logic [MAXO-1:0] v);
        for (int i = 0; i < MAXO; i++) if (!v[i]) return i;
        return -1;
    endfunction

    // Just before each rising edge: score issues, track tags and flags.
    always @(negedge clk) begin
        rocc_mem_req_s e;
        int ft;
        int rt;
        #4;
        if (reset_i) begin
            exp_q.delete();
            m_vec = '0;
            m_err = 1'b0;
        end else begin
            checks++;
            if (outstanding_o !== CW'($countones(m_vec)) || error_o !== m_err) begin
                failures++;
                $display("FAIL status: outstanding=%0d error=%0b required outstanding=%0d error=%0b",
                         outstanding_o, error_o, $countones(m_vec), m_err);
            end
            ft = lowest_free(m_vec);
            if (mem_req_valid_o && mem_req_ready_i) begin
                checks++;
                if (exp_q.size() == 0 || ft < 0) begin
                    failures++;
                    $display("FAIL issue_unexpected: tag=%0d queued=%0d free=%0d",
                             mem_req_s_o.req_tag, exp_q.size(), ft);
                end else begin
                    e = exp_q.pop_front();
                    e.req_tag = 5'(ft);
                    if (mem_req_s_o !== e) begin
                        failures++;
                        $display("FAIL issue_payload: got addr=%h tag=%0d data=%h required addr=%h tag=%0d data=%h",
                                 mem_req_s_o.req_addr, mem_req_s_o.req_tag, mem_req_s_o.req_data,
                                 e.req_addr, e.req_tag, e.req_data);
                    end
                end
            end
            if (req_v_i && req_ready_o) exp_q.push_back(req_s_i);
            if (mem_resp_valid_i) begin
                rt = int'(mem_resp_s_i.resp_tag);
                if (rt < MAXO && m_vec[rt]) m_vec[rt] = 1'b0;
                else m_err = 1'b1;
            end
            if (mem_req_valid_o && mem_req_ready_i && ft >= 0) m_vec[ft] = 1'b1;
        end
    end

    task automatic do_reset();
        reset_i          = 1'b1;
        req_v_i          = 1'b0;
        req_s_i          = '0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_s_i     = '0;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic push(input int i);
        req_v_i = 1'b1;
        req_s_i = mk(i);
        @(negedge clk);
        req_v_i = 1'b0;
    endtask

    task automatic respond(input int t);
        mem_resp_valid_i      = 1'b1;
        mem_resp_s_i          = '0;
        mem_resp_s_i.resp_tag = 5'(t);
        mem_resp_s_i.resp_data = 64'(t) ^ 64'h55;
        @(negedge clk);
        mem_resp_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (req_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0 || outstanding_o !== '0 ||
            busy_o !== 1'b0 || error_o !== 1'b0 || timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ready=%b valid=%b outst=%0d busy=%b err=%b to=%b required 1 0 0 0 0 0",
                     req_ready_o, mem_req_valid_o, outstanding_o, busy_o, error_o, timeout_o);
        end
    endtask

    task automatic test_back_to_back();
        int peak = 0;
        int n = 0;
        do_reset();
        mem_req_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_v_i = 1'b1;
            req_s_i = mk(i);
            @(negedge clk);
        end
        req_v_i = 1'b0;
        while (outstanding_o !== CW'(3) && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) begin
            if (int'(outstanding_o) > peak) peak = int'(outstanding_o);
            @(negedge clk);
        end
        for (int t = 0; t < 3; t++) begin
            if (int'(outstanding_o) > peak) peak = int'(outstanding_o);
            respond(t);
        end
        checks++;
        if (peak != 3) begin
            failures++;
            $display("FAIL b2b_peak: peak=%0d required 3", peak);
        end
        checks++;
        if (outstanding_o !== '0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: outst=%0d busy=%b required 0 0", outstanding_o, busy_o);
        end
    endtask

    task automatic test_backpressure();
        rocc_mem_req_s first;
        rocc_mem_req_s exp0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_v_i = 1'b1;
            req_s_i = mk(10 + i);
            @(negedge clk);
        end
        req_v_i = 1'b0;
        exp0 = mk(10);
        exp0.req_tag = '0;
        checks++;
        if (req_ready_o !== 1'b0 || mem_req_valid_o !== 1'b1 || mem_req_s_o !== exp0) begin
            failures++;
            $display("FAIL bp_hold: ready=%b valid=%b addr=%h tag=%0d required 0 1 addr=%h tag=0",
                     req_ready_o, mem_req_valid_o, mem_req_s_o.req_addr, mem_req_s_o.req_tag, exp0.req_addr);
        end
        first = mem_req_s_o;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req_valid_o !== 1'b1 || mem_req_s_o !== first) begin
            failures++;
            $display("FAIL bp_stable: valid=%b addr=%h tag=%0d required 1 addr=%h tag=%0d",
                     mem_req_valid_o, mem_req_s_o.req_addr, mem_req_s_o.req_tag,
                     first.req_addr, first.req_tag);
        end
        mem_req_ready_i = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (outstanding_o !== CW'(4) || busy_o !== 1'b1 || req_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: outst=%0d busy=%b ready=%b valid=%b required 4 1 1 0",
                     outstanding_o, busy_o, req_ready_o, mem_req_valid_o);
        end
    endtask

    task automatic test_full();
        do_reset();
        mem_req_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_v_i = 1'b1;
            req_s_i = mk(20 + i);
            @(negedge clk);
        end
        req_v_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req_valid_o !== 1'b0 || outstanding_o !== CW'(4) || busy_o !== 1'b1 || req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL full_stall: valid=%b outst=%0d busy=%b ready=%b required 0 4 1 1",
                     mem_req_valid_o, outstanding_o, busy_o, req_ready_o);
        end
        respond(2);
        checks++;
        if (mem_req_valid_o !== 1'b1 || mem_req_s_o.req_tag !== 5'd2) begin
            failures++;
            $display("FAIL full_reissue: valid=%b tag=%0d required 1 2", mem_req_valid_o, mem_req_s_o.req_tag);
        end
        @(negedge clk);
        checks++;
        if (outstanding_o !== CW'(4) || mem_req_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL full_after: outst=%0d valid=%b busy=%b required 4 0 1",
                     outstanding_o, mem_req_valid_o, busy_o);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        mem_req_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) push(30 + i);
        repeat (3) @(negedge clk);
        mem_req_ready_i = 1'b0;
        push(33);
        checks++;
        if (mem_req_valid_o !== 1'b1 || mem_req_s_o.req_tag !== 5'd3) begin
            failures++;
            $display("FAIL simul_head: valid=%b tag=%0d required 1 3", mem_req_valid_o, mem_req_s_o.req_tag);
        end
        mem_req_ready_i = 1'b1;
        respond(1);
        mem_req_ready_i = 1'b0;
        checks++;
        if (outstanding_o !== CW'(3)) begin
            failures++;
            $display("FAIL simul_count: outst=%0d required 3", outstanding_o);
        end
        push(34);
        checks++;
        if (mem_req_valid_o !== 1'b1 || mem_req_s_o.req_tag !== 5'd1) begin
            failures++;
            $display("FAIL simul_reuse: valid=%b tag=%0d required 1 1", mem_req_valid_o, mem_req_s_o.req_tag);
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (outstanding_o !== CW'(4)) begin
            failures++;
            $display("FAIL simul_final: outst=%0d required 4", outstanding_o);
        end
    endtask

    task automatic test_error();
        do_reset();
        respond(3);
        checks++;
        if (error_o !== 1'b1 || outstanding_o !== '0) begin
            failures++;
            $display("FAIL err_set: err=%b outst=%0d required 1 0", error_o, outstanding_o);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (error_o !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: err=%b required 1", error_o);
        end
        do_reset();
        checks++;
        if (error_o !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: err=%b required 0", error_o);
        end
        mem_req_ready_i = 1'b1;
        push(40);
        repeat (3) @(negedge clk);
        do_reset();
        respond(0);
        checks++;
        if (error_o !== 1'b1 || outstanding_o !== '0) begin
            failures++;
            $display("FAIL err_late: err=%b outst=%0d required 1 0", error_o, outstanding_o);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req_ready_i = 1'b1;
        push(50);
`ifdef BSG_ROCC_MEM_TRACKER_TIMEOUT_EN
        checks++;
        if (mem_req_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL to_issue: valid=%b required 1", mem_req_valid_o);
        end
        @(negedge clk);
        repeat (15) @(negedge clk);
        checks++;
        if (timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL to_early: timeout=%b required 0 at 15 cycles", timeout_o);
        end
        @(negedge clk);
        checks++;
        if (timeout_o !== 1'b1 || outstanding_o !== CW'(1)) begin
            failures++;
            $display("FAIL to_fire: timeout=%b outst=%0d required 1 1 at 16 cycles", timeout_o, outstanding_o);
        end
`else
        repeat (25) @(negedge clk);
        checks++;
        if (timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL to_off: timeout=%b required 0", timeout_o);
        end
`endif
    endtask

    initial begin
        reset_i          = 1'b1;
        req_v_i          = 1'b0;
        req_s_i          = '0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_s_i     = '0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_full();
        test_simultaneous();
        test_error();
        test_timeout();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
